// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and pin-mode encoding for the PWM peripheral.
// The bench imports this package as well as the RTL.
package pwm_peripheral_pkg;

  localparam int NUM_PINS        = 16;
  localparam int DEF_CLK_DIV     = 13;
  localparam int PWM_PERIOD_BITS = 8;
  localparam logic [PWM_PERIOD_BITS-1:0] DUTY_FULL = 8'hFF;

  typedef enum logic [1:0] {
    PIN_OFF    = 2'd0,
    PIN_STATIC = 2'd1,
    PIN_PWM    = 2'd2
  } pin_mode_e;

  // Output enable dominates; the PWM select only matters for enabled pins.
  function automatic pin_mode_e pin_mode(input logic en_o, input logic en_p);
    if (!en_o) return PIN_OFF;
    if (!en_p) return PIN_STATIC;
    return PIN_PWM;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Register-side bundle: configuration in from the SPI register block,
// pin drive and period strobe out.
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral_timebase.sv
// Shared PWM timebase: prescaler, period counter, duty shadow and period strobe.
// The duty shadow only reloads at the period wrap so a mid-period write never makes a runt pulse.
module pwm_timebase
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int PERIOD_BITS = PWM_PERIOD_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PERIOD_BITS-1:0] duty,
  output logic                   pwm_level,
  output logic                   period_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]          PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PERIOD_BITS-1:0] CNT_MAX   = '1;

  logic [PW-1:0]          presc;
  logic [PERIOD_BITS-1:0] cnt;
  logic [PERIOD_BITS-1:0] shadow;
  logic                   step;
  logic                   wrap;

  assign step = (presc == PRESC_MAX);
  assign wrap = step && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      cnt          <= '0;
      shadow       <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= step ? '0 : presc + 1'b1;
      if (step) cnt <= cnt + 1'b1;
      if (wrap) shadow <= duty;
      period_start <= wrap;
    end
  end

  // All-ones duty is forced high so full scale has no single low step at the wrap.
  assign pwm_level = (shadow == '1) || (cnt < shadow);

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral top: per-pin OFF/STATIC/PWM mux over a shared timebase,
// with a registered 16-pin output.
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int PERIOD_BITS = PWM_PERIOD_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  logic [NUM_PINS-1:0] en_out;
  logic [NUM_PINS-1:0] en_pwm;
  logic [NUM_PINS-1:0] out_nxt;
  logic [NUM_PINS-1:0] out_q;
  logic                pwm_level;
  logic                period_start;

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV     (CLK_DIV),
    .PERIOD_BITS (PERIOD_BITS)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty         (PERIOD_BITS'(bus.pwm_duty_cycle)),
    .pwm_level    (pwm_level),
    .period_start (period_start)
  );

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    pin_mode_e mode;
    logic      pin_d;

    assign mode = pin_mode(en_out[i], en_pwm[i]);

    always_comb begin
      pin_d = 1'b0;
      case (mode)
        PIN_STATIC: pin_d = 1'b1;
        PIN_PWM:    pin_d = pwm_level;
        default:    pin_d = 1'b0;
      endcase
    end

    assign out_nxt[i] = pin_d;
  end

  // Enables act on the next edge; only the duty is deferred to the period wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_nxt;
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: closed-form cycle scoreboard,
// a static-mode vector table and hand sequences for the multi-period cases.
module tb_pwm_peripheral;
  import pwm_peripheral_pkg::*;

  localparam int DIV = 13;
  localparam int PER = DIV * 256;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  pwm_peripheral_if bus_if ();

  pwm_peripheral #(.CLK_DIV(DIV), .PERIOD_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    bus_if.en_reg_out_7_0  = eo[7:0];
    bus_if.en_reg_out_15_8 = eo[15:8];
    bus_if.en_reg_pwm_7_0  = ep[7:0];
    bus_if.en_reg_pwm_15_8 = ep[15:8];
  endtask

  // Scoreboard: expected {period_start, out} derived from edges since reset
  // release (prescaler = n % DIV, counter = n / DIV % 256), pushed at the edge
  // and popped at the following falling edge.
  logic [16:0] sb_q[$];
  int          n_m;
  logic [7:0]  sh_m;

  initial begin
    logic [16:0] e;
    logic [15:0] eo, ep, eout;
    int          cnt_m;
    logic        lvl, eps;
    n_m  = 0;
    sh_m = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        n_m  = 0;
        sh_m = 8'h00;
        sb_q.push_back(17'h0);
      end else begin
        eo    = {bus_if.en_reg_out_15_8, bus_if.en_reg_out_7_0};
        ep    = {bus_if.en_reg_pwm_15_8, bus_if.en_reg_pwm_7_0};
        cnt_m = (n_m / DIV) % 256;
        lvl   = (sh_m == 8'hFF) || (cnt_m < int'(sh_m));
        eout  = (eo & ~ep) | (eo & ep & {16{lvl}});
        eps   = ((n_m + 1) % PER) == 0;
        if (eps) sh_m = bus_if.pwm_duty_cycle;
        n_m++;
        sb_q.push_back({eps, eout});
      end
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_out_ps", {15'h0, bus_if.period_start, bus_if.out}, {15'h0, e});
      end
    end
  end

  task automatic wait_ps(input int bound, output int waited, output int nz);
    waited = 0;
    nz     = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waited++;
      if (bus_if.out != 16'h0) nz++;
    end while (!bus_if.period_start && waited < bound);
    chk("ps_seen", {31'h0, bus_if.period_start}, 32'd1);
  endtask

  // One full period starting at the falling edge after a period_start; counts pin-0 high samples.
  task automatic run_period(input logic [7:0] d0, input int chg_at, input logic [7:0] d1,
                            output int highs);
    int others;
    int ps_early;
    others   = 0;
    ps_early = 0;
    highs    = 0;
    bus_if.pwm_duty_cycle = d0;
    for (int j = 1; j <= PER; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.out[0]) highs++;
      if (bus_if.out[15:1] != 15'h0) others++;
      if (j < PER && bus_if.period_start) ps_early++;
      if (j == chg_at) bus_if.pwm_duty_cycle = d1;
    end
    chk("period_end_ps", {31'h0, bus_if.period_start}, 32'd1);
    chk("other_pins_low", 32'(others), 32'd0);
    chk("no_early_ps", 32'(ps_early), 32'd0);
  endtask

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  duty;
    logic [15:0] exp_out;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   rel, waited, nz, highs;

    // First period after reset has shadow 0, so PWM pins read low whatever the duty.
    tbl[0] = '{16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};
    tbl[1] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 8'h80, 16'h0000};
    tbl[3] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
    tbl[4] = '{16'h00FF, 16'h0000, 8'hFF, 16'h00FF};
    tbl[5] = '{16'h1234, 16'h1230, 8'h40, 16'h0004};

    rst_n = 1'b1;
    set_en(16'h0, 16'h0);
    bus_if.pwm_duty_cycle = 8'h00;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {16'h0, bus_if.out}, 32'h0);
    chk("reset_ps", {31'h0, bus_if.period_start}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    rel = cyc;

    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #2;
      set_en(tbl[k].eo, tbl[k].ep);
      bus_if.pwm_duty_cycle = tbl[k].duty;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_out", k), {16'h0, bus_if.out}, {16'h0, tbl[k].exp_out});
    end

    // All pins disabled across two periods; strobes every PER clocks.
    set_en(16'h0, 16'h0);
    bus_if.pwm_duty_cycle = 8'h80;
    wait_ps(PER + 100, waited, nz);
    chk("first_ps_latency", 32'(cyc - rel), 32'(PER));
    wait_ps(PER + 100, waited, nz);
    chk("ps_interval", 32'(waited), 32'(PER));
    chk("disabled_out_low", 32'(nz), 32'd0);

    set_en(16'h0001, 16'h0001);
    run_period(8'h00, -1, 8'h00, highs);
    chk("duty80_high", 32'(highs), 32'(128 * DIV));
    run_period(8'hFF, -1, 8'h00, highs);
    chk("duty00_high", 32'(highs), 32'd0);
    for (int p = 0; p < 3; p++) begin
      run_period((p == 2) ? 8'h40 : 8'hFF, -1, 8'h00, highs);
      chk($sformatf("dutyFF_high_p%0d", p), 32'(highs), 32'(PER));
    end
    run_period(8'h40, 100 * DIV, 8'hC0, highs);
    chk("duty40_midchange", 32'(highs), 32'(64 * DIV));
    run_period(8'hC0, -1, 8'h00, highs);
    chk("dutyC0_high", 32'(highs), 32'(192 * DIV));

    // Reset with pin 0 high at counter 77.
    repeat (77 * DIV) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_reset_active", {31'h0, bus_if.out[0]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_out", {16'h0, bus_if.out}, 32'h0);
    chk("async_reset_ps", {31'h0, bus_if.period_start}, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    rel = cyc;
    wait_ps(PER + 100, waited, nz);
    chk("post_reset_ps_latency", 32'(cyc - rel), 32'(PER));
    chk("post_reset_shadow0", 32'(nz), 32'd0);
    run_period(8'hC0, -1, 8'h00, highs);
    chk("post_reset_dutyC0", 32'(highs), 32'(192 * DIV));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
